// File: rtl/sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding,
// default operand width and the 1-bit subtract cell truth tables.
package sub_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Truth tables indexed by {a, b, bin}: bit i is the cell output for input i.
  localparam logic [7:0] CELL_D_TRUTH    = 8'h96;
  localparam logic [7:0] CELL_BOUT_TRUTH = 8'h8E;

endpackage

// File: rtl/serial_subtractor_ctrl_if.sv
// Start/done handshake and operand/result bus of the bit-serial subtractor.
interface serial_subtractor_ctrl_if #(
  parameter int unsigned WIDTH = sub_ctrl_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  ready, busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, diff, borrow_out
  );
endinterface

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, built from two half-subtract
// stages whose borrows are ORed.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1;
  logic b1;
  logic b2;

  // First stage subtracts b from a, second subtracts the incoming borrow.
  always_comb begin
    d1   = a ^ b;
    b1   = ~a & b;
    d    = d1 ^ bin;
    b2   = ~d1 & bin;
    bout = b1 | b2;
  end
endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: diff = a - b computed LSB-first over WIDTH
// cycles through a single full_subtractor_cell and a registered borrow.
module serial_subtractor_ctrl
  import sub_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic                   clk,
  input logic                   rst_n,
  serial_subtractor_ctrl_if.slave bus
);
  localparam int unsigned      CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_nx;
  logic [WIDTH-1:0] diff_q;
  logic             borrow;
  logic             borrow_q;
  logic             cell_d;
  logic             cell_bout;
  logic             accept;
  logic             last;
  logic             ready;
  logic             busy;
  logic             done;

  full_subtractor_cell u_cell (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (borrow),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign accept    = (state == S_IDLE) && bus.start;
  assign last      = (state == S_RUN) && (count == LAST);
  assign result_nx = {cell_d, result[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state and handshake outputs; unknown encodings fall back to idle.
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (bus.start) state_nx = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (count == LAST) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand shift registers, borrow chain, bit counter and partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      result <= '0;
      borrow <= 1'b0;
      count  <= '0;
    end else if (accept) begin
      sa     <= bus.a;
      sb     <= bus.b;
      result <= '0;
      borrow <= 1'b0;
      count  <= '0;
    end else if (state == S_RUN) begin
      sa     <= sa >> 1;
      sb     <= sb >> 1;
      result <= result_nx;
      borrow <= cell_bout;
      // Counter holds on the last bit so it never wraps.
      if (!last) count <= count + 1'b1;
    end
  end

  // Published result, updated only on the final bit of an operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if (last) begin
      diff_q   <= result_nx;
      borrow_q <= cell_bout;
    end
  end

  assign bus.ready      = ready;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed and random checks of serial_subtractor_ctrl at WIDTH=8 and 16.
module tb_serial_subtractor_ctrl;
  import sub_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  serial_subtractor_ctrl_if #(.WIDTH(8))  bus8 ();
  serial_subtractor_ctrl_if #(.WIDTH(16)) bus16 ();

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_subtractor_ctrl #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  logic ca, cb, cbin, cd, cbout;

  full_subtractor_cell u_cell (
    .a    (ca),
    .b    (cb),
    .bin  (cbin),
    .d    (cd),
    .bout (cbout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                      input logic [7:0] ed, input logic eb);
    int dc;
    int rbad;
    logic [7:0] d;
    logic bo;
    dc = 0; rbad = 0; d = '0; bo = 1'b0;
    bus8.a = ia; bus8.b = ib; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0; bus8.a = ~ia; bus8.b = ~ib;
    chk({tag, "/busy"}, 32'(bus8.busy), 32'd1);
    for (int c = 1; c <= 40; c++) begin
      if (bus8.ready) rbad++;
      if (bus8.done) begin
        dc = c; d = bus8.diff; bo = bus8.borrow_out;
        break;
      end
      tick();
    end
    chk({tag, "/done_cycle"}, 32'(dc), 32'd9);
    chk({tag, "/diff"}, 32'(d), 32'(ed));
    chk({tag, "/borrow"}, 32'(bo), 32'(eb));
    chk({tag, "/ready_low"}, 32'(rbad), 32'd0);
    tick();
    chk({tag, "/done_pulse"}, 32'(bus8.done), 32'd0);
    chk({tag, "/ready_back"}, 32'(bus8.ready), 32'd1);
  endtask

  task automatic run16(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                       input logic [15:0] ed, input logic eb);
    int dc;
    logic [15:0] d;
    logic bo;
    dc = 0; d = '0; bo = 1'b0;
    bus16.a = ia; bus16.b = ib; bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0; bus16.a = ~ia; bus16.b = ~ib;
    for (int c = 1; c <= 60; c++) begin
      if (bus16.done) begin
        dc = c; d = bus16.diff; bo = bus16.borrow_out;
        break;
      end
      tick();
    end
    chk({tag, "/done_cycle"}, 32'(dc), 32'd17);
    chk({tag, "/diff"}, 32'(d), 32'(ed));
    chk({tag, "/borrow"}, 32'(bo), 32'(eb));
    tick();
    chk({tag, "/ready_back"}, 32'(bus16.ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  dtab, btab, ra, rb;
    logic [15:0] wa, wb;
    int nd, d1c, d2c;
    logic [7:0] d1v, d2v;
    logic b1v, b2v;
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0;
    ca = 1'b0; cb = 1'b0; cbin = 1'b0;

    // Exhaustive subtract cell against the shared truth tables.
    dtab = CELL_D_TRUTH;
    btab = CELL_BOUT_TRUTH;
    for (int i = 0; i < 8; i++) begin
      {ca, cb, cbin} = 3'(i);
      #1;
      chk("cell_d", 32'(cd), 32'(dtab[i]));
      chk("cell_bout", 32'(cbout), 32'(btab[i]));
    end

    // Reset state.
    chk("rst_ready", 32'(bus8.ready), 32'd1);
    chk("rst_busy", 32'(bus8.busy), 32'd0);
    chk("rst_done", 32'(bus8.done), 32'd0);
    chk("rst_diff", 32'(bus8.diff), 32'd0);
    chk("rst_borrow", 32'(bus8.borrow_out), 32'd0);
    #12 rst_n = 1'b1;
    tick();

    // Directed WIDTH=8 vectors.
    run8("200m55", 8'd200, 8'd55, 8'd145, 1'b0);
    run8("5m9", 8'd5, 8'd9, 8'd252, 1'b1);
    run8("0m255", 8'd0, 8'd255, 8'd1, 1'b1);
    run8("a5ma5", 8'hA5, 8'hA5, 8'd0, 1'b0);
    run8("255m0", 8'd255, 8'd0, 8'd255, 1'b0);

    // Start held high with operands changing every cycle.
    nd = 0; d1c = 0; d2c = 0; d1v = '0; d2v = '0; b1v = 1'b0; b2v = 1'b0;
    for (int c = 0; c <= 21; c++) begin
      bus8.start = (c < 19);
      if (c == 0)       begin bus8.a = 8'd100; bus8.b = 8'd30; end
      else if (c == 10) begin bus8.a = 8'd40;  bus8.b = 8'd90; end
      else              begin bus8.a = 8'(c * 7); bus8.b = 8'(c * 13); end
      if (c > 0 && bus8.done) begin
        nd++;
        if (nd == 1) begin d1c = c; d1v = bus8.diff; b1v = bus8.borrow_out; end
        else         begin d2c = c; d2v = bus8.diff; b2v = bus8.borrow_out; end
      end
      tick();
    end
    bus8.start = 1'b0;
    chk("held/done_count", 32'(nd), 32'd2);
    chk("held/done1_cycle", 32'(d1c), 32'd9);
    chk("held/diff1", 32'(d1v), 32'd70);
    chk("held/borrow1", 32'(b1v), 32'd0);
    chk("held/done2_cycle", 32'(d2c), 32'd19);
    chk("held/diff2", 32'(d2v), 32'd206);
    chk("held/borrow2", 32'(b2v), 32'd1);

    // Reset in the middle of an operation.
    bus8.a = 8'd200; bus8.b = 8'd55; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(bus8.ready), 32'd1);
    chk("midrst_busy", 32'(bus8.busy), 32'd0);
    chk("midrst_done", 32'(bus8.done), 32'd0);
    chk("midrst_diff", 32'(bus8.diff), 32'd0);
    chk("midrst_borrow", 32'(bus8.borrow_out), 32'd0);
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 3) rst_n = 1'b1;
      if (bus8.done) nd++;
      tick();
    end
    chk("midrst_no_done", 32'(nd), 32'd0);
    run8("7m3", 8'd7, 8'd3, 8'd4, 1'b0);

    // Directed WIDTH=16 vectors.
    run16("w16_0m65535", 16'd0, 16'hFFFF, 16'd1, 1'b1);
    run16("w16_1000m2000", 16'd1000, 16'd2000, 16'd64536, 1'b1);
    run16("w16_eq", 16'h5A5A, 16'h5A5A, 16'd0, 1'b0);

    // Random sweeps against (a-b) mod 2^W and a<b.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = (i % 10 == 0) ? ra : 8'($urandom);
      run8("rand8", ra, rb, 8'(ra - rb), ra < rb);
    end
    for (int i = 0; i < 1000; i++) begin
      wa = 16'($urandom);
      wb = (i % 10 == 0) ? wa : 16'($urandom);
      run16("rand16", wa, wb, 16'(wa - wb), wa < wb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
